// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its CPU, DMA and DataRAM neighbours.
// slave = arbiter view, master = surrounding pipeline/DMA/RAM view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LEN_W  = 4
);
  // CPU (MEM stage) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  // DMA / loader burst port
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic [31:0]       dma_wdata;
  logic              dma_beat;
  logic [31:0]       dma_rdata;
  logic              dma_rvalid;
  logic              dma_done;

  // DataRAM port
  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_d;
  logic              ram_we;
  logic [31:0]       ram_spo;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_beat, dma_rdata, dma_rvalid, dma_done,
    output ram_a, ram_d, ram_we,
    input  ram_spo
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_beat, dma_rdata, dma_rvalid, dma_done,
    input  ram_a, ram_d, ram_we,
    output ram_spo
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DataRAM arbiter: CPU priority, DMA bursts with a starvation-forced beat.
// Optional DMEM_ARB_STATS_EN adds a saturating stall_cnt output.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic              we_l;
  logic [LEN_W-1:0]  beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       dma_rdata;
  logic              dma_rvalid;
  logic              dma_done;

  logic              force_beat;
  logic              dma_own;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;

  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_d;
  logic              ram_we;
  logic              cpu_stall;

  // Arbitration decision shared by next-state and output logic
  always_comb begin
    force_beat = 1'b0;
    dma_own    = 1'b0;
    last_beat  = 1'b0;
    beat_addr  = base + ADDR_W'(beat_cnt);
    if (state == BURST) begin
      force_beat = (wait_cnt == WAIT_W'(MAX_WAIT));
      dma_own    = !bus.cpu_req || force_beat;
      last_beat  = dma_own && (beat_cnt == len);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.dma_req) state_next = BURST;
      BURST:   if (last_beat)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The CPU keeps the RAM whenever the DMA does not own this cycle
  always_comb begin
    ram_a     = bus.cpu_addr;
    ram_d     = bus.cpu_wdata;
    ram_we    = bus.cpu_req && bus.cpu_we;
    cpu_stall = 1'b0;
    if (dma_own) begin
      ram_a     = beat_addr;
      ram_d     = bus.dma_wdata;
      ram_we    = we_l;
      cpu_stall = bus.cpu_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base       <= '0;
      len        <= '0;
      we_l       <= 1'b0;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_done   <= last_beat;
      dma_rvalid <= dma_own && !we_l;
      if (dma_own && !we_l) dma_rdata <= bus.ram_spo;

      if (state == IDLE) begin
        if (bus.dma_req) begin
          base     <= bus.dma_addr;
          len      <= bus.dma_len;
          we_l     <= bus.dma_we;
          beat_cnt <= '0;
          wait_cnt <= '0;
        end
      end else begin
        if (dma_own) begin
          beat_cnt <= beat_cnt + LEN_W'(1);
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (cpu_stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

  assign bus.ram_a      = ram_a;
  assign bus.ram_d      = ram_d;
  assign bus.ram_we     = ram_we;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.cpu_rdata  = bus.ram_spo;
  assign bus.dma_beat   = dma_own;
  assign bus.dma_rdata  = dma_rdata;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.dma_done   = dma_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural DataRAM, IDLE vector table, burst/starvation/reset sequences
// with a queue of expected DMA read data and the cycle it must appear in.
module tb_dmem_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  dmem_arbiter #(.ADDR_W(AW), .LEN_W(LW), .MAX_WAIT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [31:0] pattern(input logic [AW-1:0] a);
    return 32'hD000_0000 | {26'd0, a};
  endfunction

  // DataRAM model: asynchronous read, synchronous write, refilled while reset is low
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= pattern(AW'(i));
    end else if (bus.ram_we) begin
      mem[bus.ram_a] <= bus.ram_d;
    end
  end
  assign bus.ram_spo = mem[bus.ram_a];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned at;
  } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    logic           req;
    logic           we;
    logic [AW-1:0]  addr;
    logic [31:0]    wdata;
    logic           exp_ram_we;
    logic           chk_rd;
    logic [31:0]    exp_rd;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_neg();
    rd_exp_t e;
    @(negedge clk);
    if (bus.dma_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("dma_rdata", bus.dma_rdata, e.data);
        chk("rvalid_cycle", cyc, e.at);
      end
    end else if (sb.size() != 0 && sb[0].at <= cyc) begin
      chk("missing_rvalid", 32'd0, 32'd1);
      e = sb.pop_front();
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_len   = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    bus.dma_req  = 1'b1;
    bus.dma_addr = a;
    bus.dma_len  = l;
    bus.dma_we   = w;
    at_neg();
    chk("req_cycle_beat", bus.dma_beat, 0);
    to_next();
    bus.dma_req  = 1'b0;
    bus.dma_addr = '0;
    bus.dma_len  = '0;
    bus.dma_we   = ~w;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic          bt;

    vecs[0] = '{1'b1, 1'b1, 6'd5, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 6'd5, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};
    vecs[2] = '{1'b1, 1'b1, 6'd9, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 6'd9, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 6'd9, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 6'd3, 32'h0,         1'b0, 1'b1, 32'hD000_0003};

    reset = 1'b0;
    quiet();
    repeat (3) to_next();
    at_neg();
    chk("rst_rvalid", bus.dma_rvalid, 0);
    chk("rst_done",   bus.dma_done, 0);
    chk("rst_rdata",  bus.dma_rdata, 0);
    chk("rst_stall",  bus.cpu_stall, 0);
    chk("rst_beat",   bus.dma_beat, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    reset = 1'b1;
    to_next();

    // CPU-only traffic in IDLE
    for (int i = 0; i < 6; i++) begin
      bus.cpu_req   = vecs[i].req;
      bus.cpu_we    = vecs[i].we;
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_wdata = vecs[i].wdata;
      at_neg();
      chk("idle_stall",  bus.cpu_stall, 0);
      chk("idle_beat",   bus.dma_beat, 0);
      chk("idle_ram_we", bus.ram_we, vecs[i].exp_ram_we);
      chk("idle_ram_a",  bus.ram_a, vecs[i].addr);
      if (vecs[i].chk_rd) chk("idle_cpu_rdata", bus.cpu_rdata, vecs[i].exp_rd);
      to_next();
    end
    quiet();

    // DMA write burst, CPU quiet
    start_burst(6'd10, 4'd3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.dma_wdata = 32'hBEEF_0000 + k;
      at_neg();
      chk("wr_beat",   bus.dma_beat, 1);
      chk("wr_ram_a",  bus.ram_a, AW'(10 + k));
      chk("wr_ram_we", bus.ram_we, 1);
      chk("wr_ram_d",  bus.ram_d, 32'hBEEF_0000 + k);
      chk("wr_done_early", bus.dma_done, 0);
      to_next();
    end
    bus.dma_wdata = '0;
    at_neg();
    chk("wr_done",       bus.dma_done, 1);
    chk("wr_beat_after", bus.dma_beat, 0);
    to_next();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 6'd12;
    at_neg();
    chk("wr_done_pulse", bus.dma_done, 0);
    chk("wr_mem_12",     bus.cpu_rdata, 32'hBEEF_0002);
    to_next();
    quiet();

    // DMA read burst wrapping past the top of the address space
    start_burst(6'd62, 4'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      a = AW'(62 + k);
      at_neg();
      chk("rd_beat",   bus.dma_beat, 1);
      chk("rd_ram_a",  bus.ram_a, a);
      chk("rd_ram_we", bus.ram_we, 0);
      sb.push_back('{pattern(a), cyc + 1});
      to_next();
    end
    at_neg();
    chk("rd_done", bus.dma_done, 1);
    chk("rd_sb_drained", sb.size(), 0);
    to_next();

    // Starvation: CPU writing every cycle, 2-beat DMA read
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 6'd30;
    bus.cpu_wdata = 32'hCAFE_0030;
    start_burst(6'd20, 4'd1, 1'b0);
    bus.dma_we = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      bt = (c == 9 || c == 18);
      at_neg();
      chk("st_beat",  bus.dma_beat, bt);
      chk("st_stall", bus.cpu_stall, bt);
      if (bt) begin
        a = (c == 9) ? 6'd20 : 6'd21;
        chk("st_ram_a",  bus.ram_a, a);
        chk("st_ram_we", bus.ram_we, 0);
        sb.push_back('{pattern(a), cyc + 1});
      end else begin
        chk("st_cpu_ram_a", bus.ram_a, 6'd30);
      end
      to_next();
    end
    at_neg();
    chk("st_done",  bus.dma_done, 1);
    chk("st_stall_after", bus.cpu_stall, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("st_stall_cnt", stall_cnt, 2);
`endif
    to_next();
    quiet();

    // Reset in the middle of a 6-beat read burst
    start_burst(6'd50, 4'd5, 1'b0);
    at_neg();
    chk("mr_beat0", bus.dma_beat, 1);
    chk("mr_a0",    bus.ram_a, 6'd50);
    sb.push_back('{pattern(6'd50), cyc + 1});
    to_next();
    at_neg();
    chk("mr_beat1", bus.dma_beat, 1);
    chk("mr_a1",    bus.ram_a, 6'd51);
    to_next();
    reset = 1'b0;
    #1;
    chk("mr_rst_beat",   bus.dma_beat, 0);
    chk("mr_rst_rvalid", bus.dma_rvalid, 0);
    chk("mr_rst_done",   bus.dma_done, 0);
    at_neg();
    to_next();
    at_neg();
    to_next();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("mr_no_beat", bus.dma_beat, 0);
      chk("mr_no_done", bus.dma_done, 0);
      to_next();
    end
    start_burst(6'd40, 4'd0, 1'b0);
    at_neg();
    chk("mr_new_beat", bus.dma_beat, 1);
    chk("mr_new_a",    bus.ram_a, 6'd40);
    sb.push_back('{pattern(6'd40), cyc + 1});
    to_next();
    at_neg();
    chk("mr_new_done", bus.dma_done, 1);
    chk("mr_sb_drained", sb.size(), 0);
    to_next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the pipeline's MEM stage (CPU port) and a burst DMA/loader port.
- The CPU has priority. A starvation counter guarantees DMA progress by stalling the CPU for one cycle when the DMA has waited too long.
- Sits between EX_MEM/MEM_WB and DataRAM. Its cpu_stall output feeds the pipeline hazard/stall logic.

Parameters:
ADDR_W, 6, RAM word-address width (matches ALUResult_mem[7:2])
LEN_W, 4, burst length field width; beats = dma_len+1
MAX_WAIT, 8, consecutive blocked DMA cycles before a forced DMA beat (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
cpu_req  input  1  MEM-stage access (MemRead|MemWrite)
cpu_we  input  1  CPU write
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  CPU read data, combinational from ram_spo
cpu_stall  output  1  CPU access not served this cycle
dma_req  input  1  burst request, sampled only in IDLE
dma_we  input  1  burst direction (1 = write), latched with request
dma_addr  input  ADDR_W  burst base word address, latched
dma_len  input  LEN_W  beats-1, latched
dma_wdata  input  32  write data for current beat, held until dma_beat
dma_beat  output  1  current beat accepted this cycle
dma_rdata  output  32  registered read data
dma_rvalid  output  1  dma_rdata valid, one cycle after a read beat
dma_done  output  1  one-cycle pulse on the last beat
ram_a  output  ADDR_W  to DataRAM a
ram_d  output  32  to DataRAM d
ram_we  output  1  to DataRAM we
ram_spo  input  32  from DataRAM spo (asynchronous read)

Behaviour:
- FSM has two states, IDLE and BURST. Registers: base, len, we_l, beat_cnt, wait_cnt, dma_rdata, dma_rvalid, dma_done.
- Reset (async, reset=0):
  - state=IDLE; all counters 0.
  - dma_rdata=0, dma_rvalid=0, dma_done=0.
  - Reset mid-burst aborts the burst with no dma_done.
- IDLE:
  - RAM is driven by the CPU: ram_a=cpu_addr, ram_d=cpu_wdata, ram_we=cpu_req&cpu_we.
  - cpu_stall=0; dma_beat=0.
  - On dma_req: latch dma_addr/dma_len/dma_we, set beat_cnt=0 and wait_cnt=0, go to BURST.
  - The first beat is possible the next cycle.
- BURST, each cycle:
  - force = (wait_cnt==MAX_WAIT).
  - DMA owns the RAM if !cpu_req or force. Otherwise the CPU owns it (same muxing as IDLE) and wait_cnt increments.
  - On a DMA-owned cycle:
    - ram_a = base+beat_cnt, modulo 2^ADDR_W (wraps).
    - ram_we=we_l; ram_d=dma_wdata.
    - dma_beat=1; beat_cnt increments; wait_cnt clears.
    - cpu_stall = cpu_req (CPU write suppressed; the pipeline must hold MEM).
  - On a read beat: dma_rdata<=ram_spo and dma_rvalid<=1 next cycle; otherwise dma_rvalid<=0.
  - A beat with beat_cnt==len sets dma_done (registered, high the cycle after the last beat) and returns to IDLE.
- Further dma_req pulses are ignored during BURST. The earliest new burst is accepted in the IDLE cycle following the return.
- cpu_rdata=ram_spo always. It is meaningful only when cpu_req&!cpu_stall.
- With MAX_WAIT=N and a continuously requesting CPU, the DMA gets exactly one beat every N+1 cycles.
- The CPU is never stalled in two consecutive cycles.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds output stall_cnt[15:0]:
  - counts cycles with cpu_stall=1;
  - saturates at 16'hFFFF;
  - resets to 0 on reset.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Idle CPU only: cpu_req=1, cpu_we=1, addr=5, data=32'hA5A5_0001, then a read of addr 5 -> cpu_rdata=32'hA5A5_0001, cpu_stall never 1, dma_beat=0.
- DMA write burst, CPU quiet: dma_addr=10, dma_len=3, dma_we=1 -> dma_beat high 4 consecutive cycles starting 1 cycle after request, ram_a=10,11,12,13, dma_done pulses once after the 4th beat.
- DMA read wrap: base=62, len=3 on ADDR_W=6 -> ram_a=62,63,0,1; dma_rvalid high each cycle after a beat with the matching RAM contents.
- Starvation: cpu_req held 1, MAX_WAIT=8, 2-beat DMA read -> first beat on the 9th BURST cycle with cpu_stall=1 that cycle only, second beat 9 cycles later, dma_done follows.
- Reset mid-burst: assert reset=0 after beat 1 of a len=5 burst -> immediate IDLE, dma_done/dma_rvalid 0, no further beats; a new dma_req after release restarts from beat 0.
- With DMEM_ARB_STATS_EN: the starvation scenario -> stall_cnt=2 at end.
